// File: rtl/ssp_rx_logic.sv
`default_nettype none
// ============================================================================
// Module      : ssp_rx_logic
// Description : SSP receive serial-to-parallel converter. Samples a
//               TI-style synchronous-serial frame on falling edges of the
//               PCLK-synchronous serial clock, assembles 8-bit words MSB
//               first, writes each completed word to the receive FIFO with a
//               one-cycle NextWord strobe and flags sticky overrun when the
//               FIFO is full at word completion.
// Revision    : 1.0 - initial release
// ============================================================================
module ssp_rx_logic (
  input  logic       PCLK,
  input  logic       CLEAR_B,
  input  logic       SSPCLKIN,
  input  logic       SSPFSSIN,
  input  logic       SSPRXD,
  input  logic       SSPRXINTR,
  output logic [7:0] RxData,
  output logic       NextWord,
  output logic       RxOverrun
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] c_LSB_COUNT = 3'd7;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_count;
  logic [2:0]  w_count_nxt;
  logic [7:0]  r_shreg;
  logic [7:0]  w_shreg_nxt;
  logic        r_sclk_q;
  logic [7:0]  r_rx_data;
  logic        r_next_word;
  logic        r_overrun;

  logic        w_sample;
  logic        w_complete;
  logic [7:0]  w_shifted;

  // Serial clock and data are already PCLK-synchronous, so a single delayed
  // copy of the serial clock is enough to find its falling edge.
  assign w_sample  = r_sclk_q & ~SSPCLKIN;
  // The word as it stands once the current data bit is shifted in; at the
  // LSB sample point this is the completed word.
  assign w_shifted = {r_shreg[6:0], SSPRXD};

  // Delayed serial clock for falling-edge detection; reset low so release
  // from reset can never look like a falling edge.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_sclk_q <= 1'b0;
    end else begin
      r_sclk_q <= SSPCLKIN;
    end
  end

  // Frame state, bit counter and shift register.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_state <= ST_IDLE;
      r_count <= 3'd0;
      r_shreg <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  // Next-state logic: frame start, shifting, word completion and resync.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shreg_nxt = r_shreg;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The data line is ignored on the frame-sync bit; data follows it.
        if (w_sample && SSPFSSIN) begin
          w_state_nxt = ST_SHIFT;
          w_count_nxt = 3'd0;
        end
      end
      ST_SHIFT: begin
        if (w_sample) begin
          if (r_count == c_LSB_COUNT) begin
            // LSB: word is complete. Frame sync here means back-to-back
            // frames, so the next sample point is already the next MSB.
            w_complete  = 1'b1;
            w_shreg_nxt = w_shifted;
            w_count_nxt = 3'd0;
            w_state_nxt = SSPFSSIN ? ST_SHIFT : ST_IDLE;
          end else if (SSPFSSIN) begin
            // Frame sync inside a word: drop the partial word and restart.
            w_count_nxt = 3'd0;
          end else begin
            w_shreg_nxt = w_shifted;
            w_count_nxt = r_count + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = 3'd0;
      end
    endcase
  end

  // FIFO write interface and overrun flag; FIFO-full is judged only at the
  // LSB sample edge.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_rx_data   <= 8'h00;
      r_next_word <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_next_word <= w_complete & ~SSPRXINTR;
      if (w_complete && !SSPRXINTR) begin
        r_rx_data <= w_shifted;
      end
      if (w_complete && SSPRXINTR) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign RxData    = r_rx_data;
  assign NextWord  = r_next_word;
  assign RxOverrun = r_overrun;

endmodule
`default_nettype wire

// File: doc/ssp_rx_logic.md
# ssp_rx_logic

Receive-side serial-to-parallel converter for the SSP, sitting directly upstream of the receive FIFO. It samples the incoming TI-style synchronous-serial frame (SSPCLKIN, SSPFSSIN, SSPRXD) in the PCLK domain and assembles 8-bit words MSB first. Each completed word is presented on RxData with a one-cycle NextWord strobe, which is the FIFO's write interface. It also detects overrun when the FIFO reports full.

## Interface
- No parameters; word width fixed at 8 bits.
- PCLK  input  1  system clock; all state changes on rising edge.
- CLEAR_B  input  1  asynchronous, active-low reset.
- SSPCLKIN  input  1  serial clock from peer, generated synchronous to PCLK, period ≥ 2 PCLK cycles.
- SSPFSSIN  input  1  frame sync, active-high pulse one SSPCLKIN period wide, preceding the MSB.
- SSPRXD  input  1  serial data, MSB first.
- SSPRXINTR  input  1  receive-FIFO full/interrupt indication from the FIFO.
- RxData  output  8  last completed word; held until the next completion.
- NextWord  output  1  one-PCLK write strobe to the FIFO.
- RxOverrun  output  1  sticky: a completed word was dropped because the FIFO was full.

## Operation
- SSPCLKIN, SSPFSSIN and SSPRXD are PCLK-synchronous, so there is no synchronizer.
- sclk_q is a registered copy of SSPCLKIN, reset to 0.
- A sample point is any PCLK rising edge where sclk_q=1 and SSPCLKIN=0 (falling edge of the serial clock).
- SSPFSSIN and SSPRXD are read only at sample points.
- State machine, two states:
  - IDLE: at a sample point with SSPFSSIN=1, go to SHIFT, bit count=0. SSPRXD at that point is ignored; the FSS pulse precedes data.
  - SHIFT: each sample point shifts SSPRXD into shreg LSB (shreg <= {shreg[6:0], SSPRXD}) and increments the 3-bit count.
  - At the sample point where count=7 (the LSB), the word completes.
- Word completion:
  - If SSPRXINTR=0: RxData <= {shreg[6:0], SSPRXD}; NextWord=1 for exactly the following PCLK cycle.
  - If SSPRXINTR=1: RxData and NextWord are unchanged; RxOverrun <= 1 (sticky until CLEAR_B).
- Continuous transfer: if SSPFSSIN=1 at the LSB sample point, the block stays in SHIFT with count=0 and the next sample point is the new MSB. Otherwise it returns to IDLE.
- Resync: SSPFSSIN=1 at any SHIFT sample point other than the LSB discards the partial word (no NextWord, no overrun) and restarts with count=0.
- Sample points are ignored in IDLE while SSPFSSIN=0.
- Reset (CLEAR_B=0, any time including mid-frame):
  - state=IDLE, count=0, shreg=0, sclk_q=0.
  - RxData=8'h00, NextWord=0, RxOverrun=0.
  - The partial word is lost.
  - Because sclk_q resets to 0, no spurious sample point occurs on release.

## Timing
- All outputs are registered.
- NextWord rises on the PCLK edge after the LSB sample edge and falls on the next edge: a one-cycle-latency, exactly-one-cycle pulse.
- RxData changes on the same edge NextWord rises and is stable for the whole NextWord-high cycle and beyond.
- Minimum word spacing is 8 sample points (≥16 PCLK cycles in continuous mode), so NextWord pulses are never adjacent.
- SSPRXINTR is evaluated at the LSB sample edge only. A FIFO that is full at the edge after completion is not the block's concern.
- RxOverrun sets on the edge after the dropped LSB sample, together with the point where NextWord would have risen.

## Test plan
- Reset then single frame: PCLK 40 ns, SSPCLKIN=PCLK/2, FSS pulse, then bits of 8'hE7 → NextWord high one cycle after the LSB sample, RxData=8'hE7, RxOverrun=0; all outputs 0 during reset.
- Continuous frames 8'h3A, 8'h29, 8'hC5 with FSS high during each LSB → three single-cycle NextWord pulses 16 PCLK apart carrying those values in order; no gaps in sampling.
- Overrun: SSPRXINTR=1 during the LSB of 8'h5A after 8'hE7 was received → no NextWord, RxData stays 8'hE7, RxOverrun=1 and remains 1 through later good frames.
- Resync: FSS reasserted after 4 bits of a frame, then a full 8'h96 → exactly one NextWord with RxData=8'h96.
- Mid-frame reset: CLEAR_B low for one PCLK after 5 bits, then a full 8'h81 frame → outputs 0 immediately on reset assertion; only 8'h81 delivered; no spurious word.
- Slow serial clock: SSPCLKIN=PCLK/6, data 8'hA5 → RxData=8'hA5 with a single one-cycle NextWord, proving one sample per falling edge.
